// File: rtl/mem_stage.sv
// mem_stage: MEM stage of the 5-stage MIPS pipeline.
// Waits for load data, aligns/merges it and hands the result to WB.
module mem_stage #(
    parameter int PASS_W = 64,
    parameter int CNT_W  = 2
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              es_to_ms_valid,
    output logic              ms_allowin,
    input  logic [31:0]       es_pc,
    input  logic              es_gr_we,
    input  logic [4:0]        es_dest,
    input  logic [31:0]       es_result,
    input  logic [31:0]       es_rt_value,
    input  logic [2:0]        es_ld_op,
    input  logic              es_ld_wait,
    input  logic              es_req_inflight,
    input  logic [PASS_W-1:0] es_pass,
    input  logic              data_sram_data_ok,
    input  logic [31:0]       data_sram_rdata,
    input  logic              ws_allowin,
    input  logic              ws_flush,
    output logic              ms_to_ws_valid,
    output logic [31:0]       ms_pc,
    output logic              ms_gr_we,
    output logic [4:0]        ms_dest,
    output logic [31:0]       ms_final_result,
    output logic [PASS_W-1:0] ms_pass,
    output logic [37:0]       ms_fwd,
    output logic              ms_fwd_blocked
);

    localparam logic [2:0] LD_NONE = 3'd0;
    localparam logic [2:0] LD_LB   = 3'd1;
    localparam logic [2:0] LD_LBU  = 3'd2;
    localparam logic [2:0] LD_LH   = 3'd3;
    localparam logic [2:0] LD_LHU  = 3'd4;
    localparam logic [2:0] LD_LW   = 3'd5;
    localparam logic [2:0] LD_LWL  = 3'd6;
    localparam logic [2:0] LD_LWR  = 3'd7;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic              ms_valid_q, ms_valid_d;
    logic              ld_pend_q, ld_pend_d;
    logic              rbuf_valid_q, rbuf_valid_d;
    logic [31:0]       rbuf_q, rbuf_d;
    logic [CNT_W-1:0]  cancel_cnt_q, cancel_cnt_d;
    logic [31:0]       pc_q, pc_d;
    logic              gr_we_q, gr_we_d;
    logic [4:0]        dest_q, dest_d;
    logic [31:0]       result_q, result_d;
    logic [31:0]       rt_q, rt_d;
    logic [2:0]        ld_op_q, ld_op_d;
    logic [PASS_W-1:0] pass_q, pass_d;

    logic              ms_ready_go;
    logic              accept;
    logic              handoff;
    logic              data_hit;
    logic              cap_cur;
    logic              cap_new;
    logic              inc_mem;
    logic              inc_es;
    logic              dec;
    logic [CNT_W:0]    cnt_sum;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [31:0]       final_res;

    assign ms_ready_go    = !ld_pend_q || rbuf_valid_q;
    assign ms_to_ws_valid = ms_valid_q && ms_ready_go;
    assign ms_allowin     = !ms_valid_q || (ms_ready_go && ws_allowin);
    assign accept         = es_to_ms_valid && ms_allowin && !ws_flush;
    assign handoff        = ms_to_ws_valid && ws_allowin;

    // A response only belongs to a live instruction once all cancelled ones drained
    assign data_hit = data_sram_data_ok && (cancel_cnt_q == '0);
    assign cap_cur  = data_hit && ms_valid_q && ld_pend_q;
    assign cap_new  = data_hit && accept && es_ld_wait && !cap_cur;

    assign inc_mem = ws_flush && ms_valid_q && ld_pend_q && !data_hit;
    assign inc_es  = ws_flush && es_req_inflight;
    assign dec     = data_sram_data_ok && (cancel_cnt_q != '0);

    always_comb begin
        ms_valid_d   = ms_valid_q;
        ld_pend_d    = ld_pend_q;
        rbuf_valid_d = rbuf_valid_q;
        rbuf_d       = rbuf_q;
        pc_d         = pc_q;
        gr_we_d      = gr_we_q;
        dest_d       = dest_q;
        result_d     = result_q;
        rt_d         = rt_q;
        ld_op_d      = ld_op_q;
        pass_d       = pass_q;
        if (ws_flush) begin
            ms_valid_d   = 1'b0;
            ld_pend_d    = 1'b0;
            rbuf_valid_d = 1'b0;
        end else if (accept) begin
            ms_valid_d   = 1'b1;
            ld_pend_d    = es_ld_wait && !cap_new;
            rbuf_valid_d = cap_new;
            pc_d         = es_pc;
            gr_we_d      = es_gr_we;
            dest_d       = es_dest;
            result_d     = es_result;
            rt_d         = es_rt_value;
            ld_op_d      = es_ld_op;
            pass_d       = es_pass;
        end else begin
            if (handoff) begin
                ms_valid_d   = 1'b0;
                rbuf_valid_d = 1'b0;
            end
            if (cap_cur) begin
                ld_pend_d    = 1'b0;
                rbuf_valid_d = 1'b1;
            end
        end
        if (cap_cur || cap_new) begin
            rbuf_d = data_sram_rdata;
        end
        cnt_sum = {1'b0, cancel_cnt_q}
                + {{CNT_W{1'b0}}, inc_mem}
                + {{CNT_W{1'b0}}, inc_es}
                - {{CNT_W{1'b0}}, dec};
        cancel_cnt_d = cnt_sum[CNT_W] ? CNT_MAX : cnt_sum[CNT_W-1:0];
    end

    always_comb begin
        ld_byte   = rbuf_q[{result_q[1:0], 3'b000} +: 8];
        ld_half   = result_q[1] ? rbuf_q[31:16] : rbuf_q[15:0];
        final_res = result_q;
        unique case (ld_op_q)
            LD_NONE: final_res = result_q;
            LD_LB:   final_res = {{24{ld_byte[7]}}, ld_byte};
            LD_LBU:  final_res = {24'd0, ld_byte};
            LD_LH:   final_res = {{16{ld_half[15]}}, ld_half};
            LD_LHU:  final_res = {16'd0, ld_half};
            LD_LW:   final_res = rbuf_q;
            LD_LWL: begin
                unique case (result_q[1:0])
                    2'd0: final_res = {rbuf_q[7:0], rt_q[23:0]};
                    2'd1: final_res = {rbuf_q[15:0], rt_q[15:0]};
                    2'd2: final_res = {rbuf_q[23:0], rt_q[7:0]};
                    2'd3: final_res = rbuf_q;
                endcase
            end
            LD_LWR: begin
                unique case (result_q[1:0])
                    2'd0: final_res = rbuf_q;
                    2'd1: final_res = {rt_q[31:24], rbuf_q[31:8]};
                    2'd2: final_res = {rt_q[31:16], rbuf_q[31:16]};
                    2'd3: final_res = {rt_q[31:8], rbuf_q[31:24]};
                endcase
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ms_valid_q   <= 1'b0;
            ld_pend_q    <= 1'b0;
            rbuf_valid_q <= 1'b0;
            rbuf_q       <= '0;
            cancel_cnt_q <= '0;
            pc_q         <= '0;
            gr_we_q      <= 1'b0;
            dest_q       <= '0;
            result_q     <= '0;
            rt_q         <= '0;
            ld_op_q      <= '0;
            pass_q       <= '0;
        end else begin
            ms_valid_q   <= ms_valid_d;
            ld_pend_q    <= ld_pend_d;
            rbuf_valid_q <= rbuf_valid_d;
            rbuf_q       <= rbuf_d;
            cancel_cnt_q <= cancel_cnt_d;
            pc_q         <= pc_d;
            gr_we_q      <= gr_we_d;
            dest_q       <= dest_d;
            result_q     <= result_d;
            rt_q         <= rt_d;
            ld_op_q      <= ld_op_d;
            pass_q       <= pass_d;
        end
    end

    assign ms_pc           = pc_q;
    assign ms_gr_we        = gr_we_q;
    assign ms_dest         = dest_q;
    assign ms_pass         = pass_q;
    assign ms_final_result = final_res;
    assign ms_fwd          = {final_res, ms_valid_q && gr_we_q && (dest_q != 5'd0), dest_q};
    assign ms_fwd_blocked  = ms_valid_q && ld_pend_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed load cases, then random traffic with flushes
// checked by a scoreboard against an in-order response model.
module tb_mem_stage;

    localparam int PASS_W = 64;

    logic              clk = 1'b0;
    logic              resetn;
    logic              es_to_ms_valid;
    logic              ms_allowin;
    logic [31:0]       es_pc;
    logic              es_gr_we;
    logic [4:0]        es_dest;
    logic [31:0]       es_result;
    logic [31:0]       es_rt_value;
    logic [2:0]        es_ld_op;
    logic              es_ld_wait;
    logic              es_req_inflight;
    logic [PASS_W-1:0] es_pass;
    logic              data_sram_data_ok;
    logic [31:0]       data_sram_rdata;
    logic              ws_allowin;
    logic              ws_flush;
    logic              ms_to_ws_valid;
    logic [31:0]       ms_pc;
    logic              ms_gr_we;
    logic [4:0]        ms_dest;
    logic [31:0]       ms_final_result;
    logic [PASS_W-1:0] ms_pass;
    logic [37:0]       ms_fwd;
    logic              ms_fwd_blocked;

    mem_stage #(.PASS_W(PASS_W), .CNT_W(2)) dut (
        .clk(clk), .resetn(resetn),
        .es_to_ms_valid(es_to_ms_valid), .ms_allowin(ms_allowin),
        .es_pc(es_pc), .es_gr_we(es_gr_we), .es_dest(es_dest),
        .es_result(es_result), .es_rt_value(es_rt_value),
        .es_ld_op(es_ld_op), .es_ld_wait(es_ld_wait),
        .es_req_inflight(es_req_inflight), .es_pass(es_pass),
        .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
        .ws_allowin(ws_allowin), .ws_flush(ws_flush),
        .ms_to_ws_valid(ms_to_ws_valid), .ms_pc(ms_pc), .ms_gr_we(ms_gr_we),
        .ms_dest(ms_dest), .ms_final_result(ms_final_result), .ms_pass(ms_pass),
        .ms_fwd(ms_fwd), .ms_fwd_blocked(ms_fwd_blocked)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    bit sb_on = 1'b0;

    typedef struct {
        logic [31:0] pc;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] res;
        logic [63:0] pass;
    } exp_t;

    typedef struct {
        int          id;
        logic [31:0] rdata;
    } rsp_t;

    exp_t exp_q[$];
    rsp_t rsp_q[$];

    bit          in_mem = 0, cur_load = 0, got_data = 0, cur_fwdv = 0, pres = 0;
    int          cur_id = -1, nid = 0;
    logic [31:0] cur_res;
    logic [4:0]  cur_dest;
    logic [2:0]  p_op;
    logic [31:0] p_addr, p_rt, p_pc;
    logic [4:0]  p_dest;
    logic        p_we;
    logic [63:0] p_pass;
    logic [4:0]  last_dest;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h want %h", nm, act, req);
        end
    endtask

    task automatic chkb(input string nm, input logic act, input logic req);
        chk(nm, {63'd0, act}, {63'd0, req});
    endtask

    // Memory is little-endian; loads are described by byte shifts and masks.
    function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [31:0] addr,
                                             input logic [31:0] rt, input logic [31:0] w);
        int a;
        logic [31:0] b, h;
        logic [63:0] m;
        a = int'(addr[1:0]);
        b = (w >> (8 * a)) & 32'hFF;
        h = (w >> (16 * (a / 2))) & 32'hFFFF;
        case (op)
            3'd0: return addr;
            3'd1: return b[7] ? (b | 32'hFFFFFF00) : b;
            3'd2: return b;
            3'd3: return h[15] ? (h | 32'hFFFF0000) : h;
            3'd4: return h;
            3'd5: return w;
            3'd6: begin
                m = 64'hFFFFFFFF >> (8 * (a + 1));
                return (w << (8 * (3 - a))) | (rt & m[31:0]);
            end
            default: begin
                m = 64'hFFFFFFFF >> (8 * a);
                return (w >> (8 * a)) | (rt & ~m[31:0]);
            end
        endcase
    endfunction

    always @(negedge clk) begin : monitor
        exp_t e;
        if (sb_on && resetn && ms_to_ws_valid && ws_allowin && !ws_flush) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_empty: handoff pc %h with nothing expected", ms_pc);
            end else begin
                e = exp_q.pop_front();
                chk("sb_result", {32'd0, ms_final_result}, {32'd0, e.res});
                chk("sb_pc", {32'd0, ms_pc}, {32'd0, e.pc});
                chk("sb_we_dest", {58'd0, ms_gr_we, ms_dest}, {58'd0, e.gr_we, e.dest});
                chk("sb_pass", ms_pass, e.pass);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] rt);
        es_to_ms_valid = 1'b1;
        es_ld_op       = op;
        es_ld_wait     = (op != 3'd0);
        es_result      = addr;
        es_rt_value    = rt;
        es_pc          = $urandom;
        last_dest      = 5'($urandom_range(1, 31));
        es_dest        = last_dest;
        es_gr_we       = 1'b1;
        es_pass        = {$urandom, $urandom};
        step();
        es_to_ms_valid = 1'b0;
        es_ld_wait     = 1'b0;
    endtask

    task automatic do_load(input string nm, input logic [2:0] op, input logic [31:0] addr,
                           input logic [31:0] rt, input logic [31:0] rd, input logic [31:0] exp,
                           input int dly, input int hold, input int stale);
        present(op, addr, rt);
        #1;
        chkb({nm, "_wait_valid"}, ms_to_ws_valid, 1'b0);
        chkb({nm, "_wait_blocked"}, ms_fwd_blocked, 1'b1);
        repeat (stale) begin
            data_sram_data_ok = 1'b1;
            data_sram_rdata   = 32'hDEADBEEF;
            step();
            data_sram_data_ok = 1'b0;
            #1;
            chkb({nm, "_stale_valid"}, ms_to_ws_valid, 1'b0);
            chkb({nm, "_stale_blocked"}, ms_fwd_blocked, 1'b1);
        end
        repeat (dly) begin
            chkb({nm, "_slow_blocked"}, ms_fwd_blocked, 1'b1);
            chkb({nm, "_slow_allowin"}, ms_allowin, 1'b0);
            step();
            #1;
        end
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = rd;
        step();
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = $urandom;
        ws_allowin        = (hold == 0);
        #1;
        repeat (hold) begin
            chkb({nm, "_hold_valid"}, ms_to_ws_valid, 1'b1);
            chk({nm, "_hold_data"}, {32'd0, ms_final_result}, {32'd0, exp});
            chkb({nm, "_hold_allowin"}, ms_allowin, 1'b0);
            step();
            #1;
        end
        ws_allowin = 1'b1;
        #1;
        chkb({nm, "_valid"}, ms_to_ws_valid, 1'b1);
        chk({nm, "_result"}, {32'd0, ms_final_result}, {32'd0, exp});
        chk({nm, "_fwd"}, {26'd0, ms_fwd}, {26'd0, exp, 1'b1, last_dest});
        chkb({nm, "_allowin"}, ms_allowin, 1'b1);
        step();
        #1;
        chkb({nm, "_gone"}, ms_to_ws_valid, 1'b0);
    endtask

    task automatic rand_cycle(input bit drain);
        rsp_t r;
        exp_t e;
        logic [31:0] rd;
        bit exp_ready, handoff, accept;
        step();
        ws_flush          = !drain && ($urandom_range(0, 19) == 0);
        ws_allowin        = drain || (!ws_flush && ($urandom_range(0, 3) != 0));
        es_req_inflight   = ws_flush && (rsp_q.size() < 2) && ($urandom_range(0, 1) == 1);
        data_sram_data_ok = (rsp_q.size() > 0) && (drain || $urandom_range(0, 2) == 0);
        data_sram_rdata   = data_sram_data_ok ? rsp_q[0].rdata : $urandom;
        if (!drain && !pres && $urandom_range(0, 2) != 0) begin
            pres   = 1'b1;
            p_op   = 3'($urandom_range(0, 7));
            if (p_op != 3'd0 && rsp_q.size() >= 3) p_op = 3'd0;
            p_addr = $urandom;
            p_rt   = $urandom;
            p_pc   = $urandom;
            p_dest = 5'($urandom_range(0, 31));
            p_we   = ($urandom_range(0, 3) != 0);
            p_pass = {$urandom, $urandom};
        end
        es_to_ms_valid = pres;
        es_ld_op       = p_op;
        es_ld_wait     = pres && (p_op != 3'd0);
        es_result      = p_addr;
        es_rt_value    = p_rt;
        es_pc          = p_pc;
        es_dest        = p_dest;
        es_gr_we       = p_we;
        es_pass        = p_pass;
        #1;
        exp_ready = in_mem && (!cur_load || got_data);
        chkb("rnd_to_ws_valid", ms_to_ws_valid, exp_ready);
        chkb("rnd_allowin", ms_allowin, !in_mem || (exp_ready && ws_allowin));
        chkb("rnd_blocked", ms_fwd_blocked, in_mem && cur_load && !got_data);
        chkb("rnd_fwd_vld", ms_fwd[5], in_mem && cur_fwdv);
        if (exp_ready)
            chk("rnd_fwd_data", {32'd0, ms_fwd[37:6]}, {32'd0, cur_res});
        handoff = exp_ready && ws_allowin && !ws_flush;
        accept  = pres && (!in_mem || (exp_ready && ws_allowin)) && !ws_flush;
        if (data_sram_data_ok) begin
            r = rsp_q.pop_front();
            if (in_mem && cur_load && r.id == cur_id) got_data = 1'b1;
        end
        if (ws_flush && in_mem) begin
            void'(exp_q.pop_back());
            in_mem = 1'b0;
        end
        if (handoff) in_mem = 1'b0;
        if (es_req_inflight) begin
            rsp_q.push_back('{id: nid, rdata: $urandom});
            nid++;
        end
        if (accept) begin
            e.pc    = p_pc;
            e.gr_we = p_we;
            e.dest  = p_dest;
            e.pass  = p_pass;
            e.res   = p_addr;
            cur_load = (p_op != 3'd0);
            got_data = 1'b0;
            if (cur_load) begin
                rd = $urandom;
                rsp_q.push_back('{id: nid, rdata: rd});
                cur_id = nid;
                nid++;
                e.res = ref_load(p_op, p_addr, p_rt, rd);
            end
            exp_q.push_back(e);
            in_mem   = 1'b1;
            cur_res  = e.res;
            cur_dest = p_dest;
            cur_fwdv = p_we && (p_dest != 5'd0);
            pres     = 1'b0;
        end
    endtask

    initial begin
        int n;
        resetn            = 1'b0;
        es_to_ms_valid    = 1'b0;
        es_pc             = '0;
        es_gr_we          = 1'b0;
        es_dest           = '0;
        es_result         = '0;
        es_rt_value       = '0;
        es_ld_op          = '0;
        es_ld_wait        = 1'b0;
        es_req_inflight   = 1'b0;
        es_pass           = '0;
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = '0;
        ws_allowin        = 1'b1;
        ws_flush          = 1'b0;
        last_dest         = '0;
        repeat (3) @(posedge clk);
        #1;
        chkb("rst_to_ws_valid", ms_to_ws_valid, 1'b0);
        chkb("rst_allowin", ms_allowin, 1'b1);
        chkb("rst_blocked", ms_fwd_blocked, 1'b0);
        chk("rst_fwd", {26'd0, ms_fwd}, 64'd0);
        chk("rst_pc", {32'd0, ms_pc}, 64'd0);
        resetn = 1'b1;

        do_load("lb", 3'd1, 32'h0000_1003, 32'h0, 32'h8012_3456, 32'hFFFF_FF80, 0, 0, 0);
        do_load("lwr", 3'd7, 32'h0000_2002, 32'hAABB_CCDD, 32'h1122_3344, 32'hAABB_1122, 0, 0, 0);
        do_load("lwl", 3'd6, 32'h0000_2001, 32'hAABB_CCDD, 32'h1122_3344, 32'h3344_CCDD, 0, 0, 0);
        do_load("lw_slow", 3'd5, 32'h0000_2100, 32'h0, 32'hCAFE_F00D, 32'hCAFE_F00D, 3, 0, 0);
        do_load("lw_hold", 3'd5, 32'h0000_2104, 32'h0, 32'h1234_5678, 32'h1234_5678, 1, 4, 0);

        present(3'd5, 32'h0000_3000, 32'h0);
        ws_flush   = 1'b1;
        ws_allowin = 1'b0;
        step();
        ws_flush   = 1'b0;
        ws_allowin = 1'b1;
        #1;
        chkb("flush_valid", ms_to_ws_valid, 1'b0);
        chkb("flush_allowin", ms_allowin, 1'b1);
        do_load("flush_pend", 3'd5, 32'h0000_3004, 32'h0, 32'h0BAD_F00D, 32'h0BAD_F00D, 0, 0, 1);

        present(3'd5, 32'h0000_3008, 32'h0);
        ws_flush          = 1'b1;
        ws_allowin        = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hDEAD_BEEF;
        step();
        ws_flush          = 1'b0;
        ws_allowin        = 1'b1;
        data_sram_data_ok = 1'b0;
        #1;
        chkb("flush_ok_valid", ms_to_ws_valid, 1'b0);
        chkb("flush_ok_blocked", ms_fwd_blocked, 1'b0);
        do_load("flush_ok_next", 3'd5, 32'h0000_300C, 32'h0, 32'h55AA_55AA, 32'h55AA_55AA, 0, 0, 0);

        ws_flush        = 1'b1;
        es_req_inflight = 1'b1;
        ws_allowin      = 1'b0;
        step();
        ws_flush        = 1'b0;
        es_req_inflight = 1'b0;
        ws_allowin      = 1'b1;
        do_load("inflight_lh", 3'd3, 32'h0000_4002, 32'h0, 32'h89AB_0000, 32'hFFFF_89AB, 0, 0, 1);

        ws_flush        = 1'b1;
        es_req_inflight = 1'b1;
        ws_allowin      = 1'b0;
        step();
        ws_flush        = 1'b0;
        es_req_inflight = 1'b0;
        ws_allowin      = 1'b1;
        present(3'd5, 32'h0000_5000, 32'h0);
        #1;
        chkb("midrst_blocked_before", ms_fwd_blocked, 1'b1);
        resetn = 1'b0;
        #1;
        chkb("midrst_valid", ms_to_ws_valid, 1'b0);
        chkb("midrst_allowin", ms_allowin, 1'b1);
        chkb("midrst_blocked", ms_fwd_blocked, 1'b0);
        chk("midrst_fwd", {26'd0, ms_fwd}, 64'd0);
        step();
        resetn = 1'b1;
        #1;
        do_load("post_reset_lbu", 3'd2, 32'h0000_6001, 32'h0, 32'h0000_A500, 32'h0000_00A5, 0, 0, 0);

        sb_on = 1'b1;
        for (int cyc = 0; cyc < 4000; cyc++) rand_cycle(1'b0);
        n = 0;
        while ((pres || in_mem || rsp_q.size() > 0) && n < 200) begin
            rand_cycle(1'b1);
            n++;
        end
        if (n >= 200) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: pending %0d responses, in_mem %0d", rsp_q.size(), in_mem);
        end
        es_to_ms_valid    = 1'b0;
        data_sram_data_ok = 1'b0;
        ws_flush          = 1'b0;
        es_req_inflight   = 1'b0;
        step();
        step();
        chk("sb_drained", 64'(exp_q.size()), 64'd0);
        chkb("end_valid", ms_to_ws_valid, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
